// File: rtl/rst_release_seq.sv
// Reset release sequencer: sync deassert, hold, staged domain release, tristate release.
// Optional soft-reset counter output enabled by RST_SEQ_STATUS_EN.
module rst_release_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int NUM_OUT     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               soft_rst_req,
    output logic               soft_rst_ack,
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               tristate_en,
    output logic               seq_done
`ifdef RST_SEQ_STATUS_EN
    ,
    output logic [7:0]         soft_rst_cnt
`endif
);

    localparam logic [2:0] S_SYNC = 3'd0;
    localparam logic [2:0] S_HOLD = 3'd1;
    localparam logic [2:0] S_REL  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_SOFT = 3'd4;

    localparam int CMAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW   = $clog2(CMAX + 1);

    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [NUM_OUT-1:0]     rst_q, rst_d;
    logic                   tri_q, tri_d;
    logic                   done_q, done_d;
    logic                   ack_q, ack_d;
    logic                   sync_rise;

    // The synchronizer chain shifts in a constant 1 after reset deassert;
    // the FSM leaves SYNC on the edge where the chain output first becomes 1.
    assign sync_d    = {sync_q[SYNC_STAGES-2:0], 1'b1};
    assign sync_rise = sync_d[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1];

    // Next-state logic for the release sequence and soft-reset handshake
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        tri_d   = tri_q;
        done_d  = done_q;
        ack_d   = ack_q;
        unique case (state_q)
            S_SYNC: begin
                if (sync_rise) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d  = S_REL;
                    cnt_d    = '0;
                    rst_d[0] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REL: begin
                if (cnt_q == CW'(STAGE_GAP - 1)) begin
                    cnt_d = '0;
                    if (rst_q[NUM_OUT-1]) begin
                        state_d = S_DONE;
                        tri_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // released bits are contiguous from bit 0
                        rst_d = (rst_q << 1) | NUM_OUT'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (soft_rst_req) begin
                    state_d = S_SOFT;
                    cnt_d   = '0;
                    rst_d   = '0;
                    tri_d   = 1'b1;
                    done_d  = 1'b0;
                    ack_d   = 1'b1;
                end
            end
            S_SOFT: begin
                if (!soft_rst_req) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_SYNC;
            cnt_q   <= '0;
            sync_q  <= '0;
            rst_q   <= '0;
            tri_q   <= 1'b1;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            rst_q   <= rst_d;
            tri_q   <= tri_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    assign rst_out_n    = rst_q;
    assign tristate_en  = tri_q;
    assign seq_done     = done_q;
    assign soft_rst_ack = ack_q;

`ifdef RST_SEQ_STATUS_EN
    logic [7:0] srcnt_q;

    // Saturating count of soft resets taken since the last hard reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srcnt_q <= 8'h00;
        end else if (state_q == S_DONE && soft_rst_req && srcnt_q != 8'hFF) begin
            srcnt_q <= srcnt_q + 8'h01;
        end
    end

    assign soft_rst_cnt = srcnt_q;
`endif

endmodule

// File: tb/tb_rst_release_seq.sv
// Testbench for rst_release_seq: table-driven release/soft-reset vectors
// plus hand-written reset-abort, short-pulse and small-parameter sequences.
module tb_rst_release_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       req5 = 1'b0;
    logic       ack, ack5;
    logic [3:0] rout;
    logic [0:0] rout5;
    logic       tri_o, tri5;
    logic       done_o, done5;
`ifdef RST_SEQ_STATUS_EN
    logic [7:0] scnt, scnt5;
`endif

    int cur = 0;
    int n_pass = 0;
    int n_tot = 0;

    always #5 clk = ~clk;

    rst_release_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .soft_rst_req (req),
        .soft_rst_ack (ack),
        .rst_out_n    (rout),
        .tristate_en  (tri_o),
        .seq_done     (done_o)
`ifdef RST_SEQ_STATUS_EN
        ,
        .soft_rst_cnt (scnt)
`endif
    );

    rst_release_seq #(
        .SYNC_STAGES (3),
        .HOLD_CYCLES (1),
        .STAGE_GAP   (1),
        .NUM_OUT     (1)
    ) dut5 (
        .clk          (clk),
        .rst_n        (rst_n),
        .soft_rst_req (req5),
        .soft_rst_ack (ack5),
        .rst_out_n    (rout5),
        .tristate_en  (tri5),
        .seq_done     (done5)
`ifdef RST_SEQ_STATUS_EN
        ,
        .soft_rst_cnt (scnt5)
`endif
    );

    typedef struct {
        bit         rel;
        int         e;
        logic       rq;
        logic [3:0] rst;
        logic       tv;
        logic       dn;
        logic       ak;
    } vec_t;

    vec_t tv[$];

    task automatic add(bit rel, int e, logic rq, logic [3:0] rst,
                       logic t, logic d, logic a);
        vec_t v;
        v.rel = rel; v.e = e; v.rq = rq; v.rst = rst;
        v.tv = t; v.dn = d; v.ak = a;
        tv.push_back(v);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic chk_main(string nm, logic [3:0] r, logic t, logic d, logic a);
        chk({nm, ".rst"}, 32'(rout), 32'(r));
        chk({nm, ".tri"}, 32'(tri_o), 32'(t));
        chk({nm, ".done"}, 32'(done_o), 32'(d));
        chk({nm, ".ack"}, 32'(ack), 32'(a));
    endtask

    // advance to edge e (counted from last release), sampling 1ns after it
    task automatic go_to(int e, logic r);
        while (cur < e) begin
            req = r;
            @(posedge clk);
            cur++;
            #1;
        end
    endtask

    // assert rst_n mid-cycle, check async clear, hold 5 cycles, release
    task automatic do_reset(string nm);
        rst_n = 1'b0;
        req = 1'b0;
        #1;
        chk_main({nm, ".async"}, 4'h0, 1'b1, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cur = 0;
    endtask

    initial begin
        // case 1: release timing (T0 = edge 2)
        add(1, 1,  0, 4'h0, 1, 0, 0);
        add(0, 2,  0, 4'h0, 1, 0, 0);
        add(0, 17, 0, 4'h0, 1, 0, 0);
        add(0, 18, 0, 4'h1, 1, 0, 0);
        add(0, 21, 0, 4'h1, 1, 0, 0);
        add(0, 22, 0, 4'h3, 1, 0, 0);
        add(0, 26, 0, 4'h7, 1, 0, 0);
        add(0, 29, 0, 4'h7, 1, 0, 0);
        add(0, 30, 0, 4'hF, 1, 0, 0);
        add(0, 33, 0, 4'hF, 1, 0, 0);
        add(0, 34, 0, 4'hF, 0, 1, 0);
        // case 2: soft reset, req high for 6 edges (T0' = edge 41)
        add(0, 35, 1, 4'h0, 1, 0, 1);
        add(0, 40, 1, 4'h0, 1, 0, 1);
        add(0, 41, 0, 4'h0, 1, 0, 0);
        add(0, 56, 0, 4'h0, 1, 0, 0);
        add(0, 57, 0, 4'h1, 1, 0, 0);
        add(0, 69, 0, 4'hF, 1, 0, 0);
        add(0, 72, 0, 4'hF, 1, 0, 0);
        add(0, 73, 0, 4'hF, 0, 1, 0);
        // case 3: request during HOLD ignored, fires after completion
        add(1, 1,  0, 4'h0, 1, 0, 0);
        add(0, 10, 1, 4'h0, 1, 0, 0);
        add(0, 18, 1, 4'h1, 1, 0, 0);
        add(0, 33, 1, 4'hF, 1, 0, 0);
        add(0, 34, 1, 4'hF, 0, 1, 0);
        add(0, 35, 1, 4'h0, 1, 0, 1);
        add(0, 36, 0, 4'h0, 1, 0, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].rel)
                do_reset($sformatf("rst%0d", i));
            go_to(tv[i].e, tv[i].rq);
            chk_main($sformatf("vec%0d@e%0d", i, tv[i].e),
                     tv[i].rst, tv[i].tv, tv[i].dn, tv[i].ak);
        end

        // case 4 and 5: fresh release, small-parameter instance timing
        do_reset("c4pre");
        go_to(2, 0);
        chk("c5.e2.rst", 32'(rout5), 32'd0);
        go_to(3, 0);
        chk("c5.e3.rst", 32'(rout5), 32'd0);
        go_to(4, 0);
        chk("c5.e4.rst", 32'(rout5), 32'd1);
        chk("c5.e4.done", 32'(done5), 32'd0);
        chk("c5.e4.tri", 32'(tri5), 32'd1);
        go_to(5, 0);
        chk("c5.e5.done", 32'(done5), 32'd1);
        chk("c5.e5.tri", 32'(tri5), 32'd0);
        go_to(22, 0);
        chk("c4.mid.rst", 32'(rout), 32'h3);
        rst_n = 1'b0;
        #1;
        chk_main("c4.abort", 4'h0, 1'b1, 1'b0, 1'b0);
        chk("c4.abort.rst5", 32'(rout5), 32'd0);
        chk("c4.abort.tri5", 32'(tri5), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cur = 0;
        go_to(17, 0);
        chk_main("c4.e17", 4'h0, 1'b1, 1'b0, 1'b0);
        go_to(18, 0);
        chk_main("c4.e18", 4'h1, 1'b1, 1'b0, 1'b0);
        go_to(34, 0);
        chk_main("c4.e34", 4'hF, 1'b0, 1'b1, 1'b0);

        // sub-cycle rst_n pulse between edges
        rst_n = 1'b0;
        #2;
        chk_main("pulse.async", 4'h0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        cur = 0;
        go_to(1, 0);
        chk_main("pulse.e1", 4'h0, 1'b1, 1'b0, 1'b0);
        go_to(17, 0);
        chk_main("pulse.e17", 4'h0, 1'b1, 1'b0, 1'b0);
        go_to(18, 0);
        chk_main("pulse.e18", 4'h1, 1'b1, 1'b0, 1'b0);
        go_to(34, 0);
        chk_main("pulse.e34", 4'hF, 1'b0, 1'b1, 1'b0);

`ifdef RST_SEQ_STATUS_EN
        // case 6: saturating soft-reset counter
        chk("c6.start", 32'(scnt), 32'h00);
        for (int k = 0; k < 300; k++) begin
            go_to(cur + 1, 1'b1);
            go_to(cur + 1, 1'b0);
            go_to(cur + 32, 1'b0);
            if (k == 0)
                chk("c6.one", 32'(scnt), 32'h01);
        end
        chk("c6.sat", 32'(scnt), 32'hFF);
        chk("c6.done", 32'(done_o), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("c6.clr", 32'(scnt), 32'h00);
        rst_n = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
